// File: rtl/matmul_pkg.sv
// Shared types, default widths and the row-major address helper for matmul_engine.
package matmul_pkg;

    localparam int MM_DATA_W = 8;
    localparam int MM_ACC_W  = 32;
    localparam int MM_MAX_N  = 4;
    localparam int MM_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Row-major index row*N + col; callers truncate to their address width.
    function automatic logic [7:0] mat_addr(input logic [3:0] row,
                                            input logic [3:0] col,
                                            input logic [3:0] n);
        return (8'(row) * 8'(n)) + 8'(col);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate; two's-complement operands when MATMUL_SIGNED_EN is defined.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int ACC_W  = MM_ACC_W
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc,
    output logic [ACC_W-1:0]  o_sum
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_prod_ext;

`ifdef MATMUL_SIGNED_EN
    logic signed [2*DATA_W-1:0] w_prod;
    assign w_prod = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a})
                  * $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
`else
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign w_prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
`endif

    // Sum is exposed so the final product can land in the result register without an extra cycle.
    assign o_sum = r_acc + w_prod_ext;
    assign o_acc = r_acc;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// Sequential N x N matrix multiply core streaming C in row-major order over valid/ready.
// Optional build macro: MATMUL_SIGNED_EN (two's-complement operands and results).
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int ACC_W  = MM_ACC_W,
    parameter int MAX_N  = MM_MAX_N,
    parameter int ADDR_W = MM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_data,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_data,
    output logic [ACC_W-1:0]  c_data,
    output logic              c_valid,
    input  logic              c_ready,
    output logic              c_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t r_state, w_next_state;

    logic [3:0]        r_n, r_i, r_j, r_k;
    logic [ADDR_W-1:0] r_a_addr, r_b_addr;
    logic [ACC_W-1:0]  r_c_data;
    logic              r_c_valid, r_c_last, r_busy, r_done, r_err;

    logic [3:0]       w_nm1, w_k_inc, w_i_nx, w_j_nx;
    logic             w_size_ok, w_last_elem, w_xfer;
    logic             w_mac_clr, w_mac_en;
    logic [ACC_W-1:0] w_acc, w_sum;
    logic             w_unused_hi;

    assign w_nm1       = r_n - 4'd1;
    assign w_k_inc     = r_k + 4'd1;
    assign w_size_ok   = (matrix_size != 4'd0) && (matrix_size <= 4'(MAX_N));
    assign w_last_elem = (r_i == w_nm1) && (r_j == w_nm1);
    assign w_xfer      = (r_state == ST_EMIT) && c_ready;
    assign w_i_nx      = (r_j == w_nm1) ? r_i + 4'd1 : r_i;
    assign w_j_nx      = (r_j == w_nm1) ? 4'd0 : r_j + 4'd1;
    assign w_unused_hi = ^{a_data[31:DATA_W], b_data[31:DATA_W], w_acc};

    // Read data lags its address by one cycle, so a product is ready in every
    // FETCH cycle after the first one and in DRAIN.
    assign w_mac_en  = ((r_state == ST_FETCH) && (r_k != 4'd0)) || (r_state == ST_DRAIN);
    assign w_mac_clr = (r_state == ST_IDLE) || w_xfer;

    mac_unit #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk  (clk),
        .i_clr(w_mac_clr),
        .i_en (w_mac_en),
        .i_a  (a_data[DATA_W-1:0]),
        .i_b  (b_data[DATA_W-1:0]),
        .o_acc(w_acc),
        .o_sum(w_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start && w_size_ok) w_next_state = ST_FETCH;
            ST_FETCH: if (r_k == w_nm1) w_next_state = ST_DRAIN;
            ST_DRAIN: w_next_state = ST_EMIT;
            ST_EMIT:  if (c_ready) w_next_state = w_last_elem ? ST_DONE : ST_FETCH;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_a_addr  <= '0;
            r_b_addr  <= '0;
            r_c_data  <= '0;
            r_c_valid <= 1'b0;
            r_c_last  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_size_ok) begin
                        r_n      <= matrix_size;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_a_addr <= '0;
                        r_b_addr <= '0;
                        r_busy   <= 1'b1;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (r_k != w_nm1) begin
                        r_k      <= w_k_inc;
                        r_a_addr <= ADDR_W'(mat_addr(r_i, w_k_inc, r_n));
                        r_b_addr <= ADDR_W'(mat_addr(w_k_inc, r_j, r_n));
                    end
                end
                ST_DRAIN: begin
                    r_c_data  <= w_sum;
                    r_c_valid <= 1'b1;
                    r_c_last  <= w_last_elem;
                end
                ST_EMIT: begin
                    // Addresses and result stay frozen until the consumer takes the element.
                    if (c_ready) begin
                        r_c_valid <= 1'b0;
                        r_c_last  <= 1'b0;
                        if (w_last_elem) begin
                            r_done <= 1'b1;
                        end else begin
                            r_i      <= w_i_nx;
                            r_j      <= w_j_nx;
                            r_k      <= '0;
                            r_a_addr <= ADDR_W'(mat_addr(w_i_nx, 4'd0, r_n));
                            r_b_addr <= ADDR_W'(mat_addr(4'd0, w_j_nx, r_n));
                        end
                    end
                end
                ST_DONE: begin
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign a_addr  = r_a_addr;
    assign b_addr  = r_b_addr;
    assign c_data  = r_c_data;
    assign c_valid = r_c_valid;
    assign c_last  = r_c_last;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: directed and random jobs against a plain-arithmetic model.
module tb_matmul_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int MAX_N  = 4;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        matrix_size = 4'd0;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [31:0]       a_data = '0, b_data = '0;
    logic [ACC_W-1:0]  c_data;
    logic              c_valid, c_last, busy, done, err;
    logic              c_ready = 1'b1;

    logic [31:0] mem_a[16];
    logic [31:0] mem_b[16];
    logic [31:0] exp_c[16];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        a_data <= mem_a[a_addr];
        b_data <= mem_b[b_addr];
    end

    matmul_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_N(MAX_N), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
        .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
        .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready), .c_last(c_last),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [31:0] ref_elem(input int n, input int i, input int j);
        int sum;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            logic [7:0] av, bv;
            av = mem_a[i*n + k][7:0];
            bv = mem_b[k*n + j][7:0];
`ifdef MATMUL_SIGNED_EN
            sum += int'($signed(av)) * int'($signed(bv));
`else
            sum += int'(av) * int'(bv);
`endif
        end
        return sum;
    endfunction

    task automatic fill_model(input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                exp_c[i*n + j] = ref_elem(n, i, j);
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 16; a++) begin
            mem_a[a] = '0;
            mem_b[a] = '0;
        end
    endtask

    task automatic random_mem();
        for (int a = 0; a < 16; a++) begin
            mem_a[a] = $urandom;
            mem_b[a] = $urandom;
        end
    endtask

    // Runs one job against exp_c; optional stall of one element and a start pulse while busy.
    task automatic run_job(input int n, input int stall_elem, input int stall_len,
                           input bit poke_start, input string name);
        int elem, s_cyc, stall_cnt, budget;
        bit got_done, poked;
        logic [ACC_W-1:0] h_data;
        logic [ADDR_W-1:0] h_a, h_b;
        logic h_last;
        elem = 0; stall_cnt = 0; got_done = 0; poked = 0;
        h_data = '0; h_a = '0; h_b = '0; h_last = 1'b0;
        @(negedge clk);
        start = 1'b1; matrix_size = n[3:0]; c_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; s_cyc = cyc;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        budget = n*n*(n+2) + stall_len + 40;
        for (int t = 0; t < budget && !got_done; t++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (done) begin
                got_done = 1;
                checks++;
                if (cyc + 1 - s_cyc != n*n*(n+2) + 1 + stall_len) begin
                    failures++;
                    $display("FAIL %s done_latency: got %0d want %0d", name,
                             cyc + 1 - s_cyc, n*n*(n+2) + 1 + stall_len);
                end
            end else if (c_valid) begin
                if (elem == stall_elem && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        h_data = c_data; h_a = a_addr; h_b = b_addr; h_last = c_last;
                    end else begin
                        checks++;
                        if ({c_data, c_last, a_addr, b_addr} !== {h_data, h_last, h_a, h_b}) begin
                            failures++;
                            $display("FAIL %s stall_hold: got data=%0d a=%0d b=%0d want data=%0d a=%0d b=%0d",
                                     name, c_data, a_addr, b_addr, h_data, h_a, h_b);
                        end
                    end
                    stall_cnt++;
                    c_ready = 1'b0;
                end else begin
                    c_ready = 1'b1;
                    checks++;
                    if (elem >= n*n) begin
                        failures++;
                        $display("FAIL %s extra_element: got %0d elements want %0d", name, elem + 1, n*n);
                    end else if (c_data !== exp_c[elem] || c_last !== (elem == n*n - 1)) begin
                        failures++;
                        $display("FAIL %s elem%0d: got data=%0d last=%b want data=%0d last=%b",
                                 name, elem, c_data, c_last, exp_c[elem], (elem == n*n - 1));
                    end
                    if (elem == 0) begin
                        checks++;
                        if (cyc + 1 - s_cyc != n + 2) begin
                            failures++;
                            $display("FAIL %s first_valid_latency: got %0d want %0d", name,
                                     cyc + 1 - s_cyc, n + 2);
                        end
                    end
                    elem++;
                end
            end else if (poke_start && elem == 1 && !poked) begin
                start = 1'b1; matrix_size = 4'd3; poked = 1;
            end
        end
        c_ready = 1'b1;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL %s done_timeout: got no done want done within %0d cycles", name, budget);
        end
        checks++;
        if (elem != n*n) begin
            failures++;
            $display("FAIL %s transfer_count: got %0d want %0d", name, elem, n*n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({a_addr, b_addr, c_data, c_valid, c_last, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL %s: got a=%0d b=%0d c=%0d v=%b l=%b busy=%b done=%b err=%b want all 0",
                     name, a_addr, b_addr, c_data, c_valid, c_last, busy, done, err);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_values");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_directed_2x2();
        clear_mem();
        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
        exp_c[0] = 19; exp_c[1] = 22; exp_c[2] = 43; exp_c[3] = 50;
        run_job(2, -1, 0, 0, "n2_directed");
    endtask

    task automatic test_identity_4();
        clear_mem();
        for (int a = 0; a < 16; a++) begin
            mem_b[a] = a;
            exp_c[a] = a;
        end
        for (int d = 0; d < 4; d++) mem_a[d*4 + d] = 1;
        run_job(4, -1, 0, 0, "n4_identity");
    endtask

    task automatic test_n1_max();
        clear_mem();
        mem_a[0] = 32'hDEAD_BEFF;
        mem_b[0] = 32'h1234_56FF;
`ifdef MATMUL_SIGNED_EN
        exp_c[0] = 32'd1;
`else
        exp_c[0] = 32'd65025;
`endif
        run_job(1, -1, 0, 0, "n1_max");
    endtask

    task automatic test_signed_mix();
        clear_mem();
        mem_a[0] = 32'h0000_00FF; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 32'h0000_00FC;
        for (int a = 0; a < 4; a++) mem_b[a] = 1;
`ifdef MATMUL_SIGNED_EN
        exp_c[0] = 32'd1; exp_c[1] = 32'd1; exp_c[2] = 32'hFFFF_FFFF; exp_c[3] = 32'hFFFF_FFFF;
`else
        exp_c[0] = 32'd257; exp_c[1] = 32'd257; exp_c[2] = 32'd255; exp_c[3] = 32'd255;
`endif
        run_job(2, -1, 0, 0, "n2_sign_mix");
    endtask

    task automatic test_err();
        logic [3:0] bad[2];
        bad[0] = 4'd0; bad[1] = 4'd5;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            start = 1'b1; matrix_size = bad[b];
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL err_pulse size=%0d: got err=%b busy=%b want 1 0", bad[b], err, busy);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin
                failures++;
                $display("FAIL err_single_cycle size=%0d: got %b want 0", bad[b], err);
            end
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || c_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL err_idle size=%0d: got busy=%b c_valid=%b want 0 0", bad[b], busy, c_valid);
                end
            end
        end
    endtask

    task automatic test_stall();
        random_mem();
        fill_model(2);
        run_job(2, 1, 10, 0, "n2_stall");
    endtask

    task automatic test_reset_mid_fetch();
        random_mem();
        @(negedge clk);
        start = 1'b1; matrix_size = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset_mid_fetch_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_mid_fetch_held");
        rst = 1'b1;
        fill_model(2);
        run_job(2, -1, 0, 0, "rerun_after_reset");
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            random_mem();
            n = int'($urandom_range(1, MAX_N));
            fill_model(n);
            run_job(n, -1, 0, (r == 2), $sformatf("random%0d_n%0d", r, n));
        end
        random_mem();
        fill_model(4);
        run_job(4, -1, 0, 1, "random_n4_busy_start");
    endtask

    initial begin
        test_reset();
        test_directed_2x2();
        test_identity_4();
        test_n1_max();
        test_signed_mix();
        test_err();
        test_stall();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

- Compute core between the two operand matrix memories and the UART transmit path.
- On `start`, reads matrix A and matrix B (N×N, row-major, packed with stride N) through the memories' synchronous read ports.
- Computes C = A × B one element at a time with a single multiply-accumulate datapath.
- Streams each C element, in row-major order, through a valid/ready handshake to the result serializer that feeds `uart_tx`.

## Interface
- `DATA_W`, 8: operand width; low `DATA_W` bits of `a_data`/`b_data` are used.
- `ACC_W`, 32: accumulator and result width.
- `MAX_N`, 4: largest supported matrix dimension.
- `ADDR_W`, 4: memory address width.
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begin a multiply (sampled only in IDLE).
- `matrix_size` in 4: N, sampled with `start`.
- `a_addr` out ADDR_W: matrix A read address.
- `a_data` in 32: matrix A read data, valid one cycle after `a_addr`.
- `b_addr` out ADDR_W: matrix B read address.
- `b_data` in 32: matrix B read data, valid one cycle after `b_addr`.
- `c_data` out ACC_W: result element.
- `c_valid` out 1: `c_data` valid.
- `c_ready` in 1: downstream accepts.
- `c_last` out 1: qualifies the final element C[N-1][N-1].
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last element is accepted.
- `err` out 1: one-cycle pulse when `start` has an illegal size.

## Operation
- States: IDLE → FETCH → DRAIN → EMIT → (FETCH | DONE) → IDLE.
- IDLE:
  - On `start` with 1 ≤ `matrix_size` ≤ MAX_N: latch N, clear i, j, k and the accumulator, go to FETCH.
  - On `start` with `matrix_size` = 0 or > MAX_N: pulse `err`, stay in IDLE.
- FETCH:
  - Each cycle drives `a_addr` = i·N + k and `b_addr` = k·N + j, then increments k.
  - The accumulator adds a_data × b_data for the previous k (one-cycle lag).
  - After k = N−1 is issued, go to DRAIN.
- DRAIN: one cycle; accumulate the final product, register the result into `c_data`, go to EMIT.
- EMIT:
  - Hold `c_valid` and `c_data` stable until `c_ready`.
  - On transfer, advance j (and i when j wraps from N−1 to 0), clear the accumulator and k.
  - Go to FETCH, or to DONE after C[N−1][N−1].
- DONE: pulse `done`, go to IDLE.
- Arithmetic:
  - Unsigned DATA_W×DATA_W → 2·DATA_W product, zero-extended to ACC_W.
  - Accumulation is modulo 2^ACC_W; no overflow for the default widths.
- `start` while `busy` is ignored.
- `c_ready` low stalls indefinitely with no address activity.
- `c_ready` high on the same cycle `c_valid` rises completes the transfer that cycle.
- Reset low at any time aborts the operation and returns to IDLE.

## Timing
- Reset values:
  - `a_addr`, `b_addr`, `c_data` = 0.
  - `c_valid`, `c_last`, `busy`, `done`, `err` = 0.
  - State = IDLE.
- `busy` rises the cycle after an accepted `start`.
- First `c_valid` appears N+2 cycles after `start` is sampled (N FETCH + 1 DRAIN + EMIT entry).
- Per element: N+2 cycles from leaving EMIT to the next `c_valid`, plus any stall.
- Total with `c_ready` tied high: N²·(N+2) + 1 cycles from `start` to `done`.
- `err` and `done` are registered single-cycle pulses.
- All outputs are registered.

## Configuration
- `MATMUL_SIGNED_EN` defined:
  - Operands are two's complement.
  - Products are sign-extended to ACC_W.
  - `c_data` is a signed result.
- `MATMUL_SIGNED_EN` undefined: unsigned arithmetic as described above.
- Handshake, timing and addressing are identical in both builds.

## Structure
- `matmul_pkg` holds:
  - The state enum (IDLE, FETCH, DRAIN, EMIT, DONE).
  - MAX_N, DATA_W and ACC_W defaults.
  - The address-computation helper function.
- Sub-module `mac_unit`:
  - Registered multiply-accumulate with `clr` and `en` inputs.
  - Signedness selected by `MATMUL_SIGNED_EN`.

## Test plan
- N=2, A=[1,2;3,4], B=[5,6;7,8], `c_ready`=1 → outputs 19, 22, 43, 50; `c_last` on 50; `done` at cycle 17.
- N=4, A=identity, B = values 0..15 → C equals B in order; 16 transfers, `done` once.
- N=1, A=255, B=255 → single output 65025 with `c_last`=1; `done` 4 cycles after `start`.
- `start` with `matrix_size`=0 and again with 5 → `err` pulses each time, `busy` stays 0, no `c_valid`.
- N=2, `c_ready` low for 10 cycles on the second element → `c_data` and `c_valid` held; addresses frozen; results unchanged.
- Reset asserted mid-FETCH, then `start` N=2 → all outputs 0 during reset, clean rerun, correct results.
- `MATMUL_SIGNED_EN` build, N=2, A=[-1,2;3,-4], B=[1,1;1,1] → outputs 1, 1, −1, −1.
